nco_sweep_controller: RTL and testbench
=======================================

# nco_sweep_controller

Sequencer for the phase-increment input of the NCO sine/cosine generator. Accepts a frequency plan (single tone, one-shot sweep or repeating sweep) over a valid/ready handshake. Steps the NCO phase increment from a start to a stop value, holding each value for a programmable number of sample enables. Sits between the control register interface and the NCO, sharing its `sample_clk_ce` so all frequency changes land on sample boundaries.

## Interface
- `PHASE_WIDTH`, 64, width of signed phase increment (matches NCO)
- `DWELL_WIDTH`, 16, width of dwell counter
- `clk`  in  1  system clock
- `arst_n`  in  1  asynchronous active-low reset
- `sample_clk_ce`  in  1  sample clock enable, same strobe that drives the NCO accumulator
- `cfg_valid`  in  1  configuration offered
- `cfg_ready`  out  1  controller can accept configuration
- `cfg_mode`  in  2  0 = TONE, 1 = ONESHOT, 2 = REPEAT, 3 = reserved (treated as TONE)
- `cfg_start_inc`  in  PHASE_WIDTH  signed start increment
- `cfg_stop_inc`  in  PHASE_WIDTH  signed stop increment
- `cfg_step_inc`  in  PHASE_WIDTH  signed step per dwell period
- `cfg_dwell`  in  DWELL_WIDTH  sample enables per value; 0 behaves as 1
- `abort`  in  1  terminate current plan
- `phase_increment`  out  PHASE_WIDTH  signed, registered, drives NCO
- `busy`  out  1  state != IDLE
- `step_strobe`  out  1  one-cycle pulse whenever `phase_increment` is loaded
- `sweep_done`  out  1  one-cycle pulse at end of each sweep pass

## Operation
- Reset: state IDLE; `phase_increment` = 0; all config registers 0; `cfg_ready` = 1; `busy`, `step_strobe` and `sweep_done` = 0.
- `cfg_ready` = (state == IDLE) && !abort. Accept on `cfg_valid && cfg_ready`; latch all `cfg_*` fields; go to ARM.
- ARM: wait for `sample_clk_ce`.
  - On the enable, load `phase_increment` <= start and `dwell_cnt` <= max(dwell,1) − 1, and pulse `step_strobe`.
  - TONE then goes to IDLE. All other modes go to DWELL.
- DWELL, on each `sample_clk_ce`:
  - If `dwell_cnt` != 0: decrement it.
  - Else, if `phase_increment` == stop: end of pass. Pulse `sweep_done`.
    - ONESHOT goes to IDLE and holds stop.
    - REPEAT loads start, reloads `dwell_cnt`, pulses `step_strobe` and stays in DWELL.
  - Else: compute `next` = current + step in PHASE_WIDTH+1 signed bits (no wrap).
    - Overshoot is `next` > stop when step > 0, or `next` < stop when step < 0.
    - On overshoot, load stop; otherwise load `next`.
    - Reload `dwell_cnt` and pulse `step_strobe`.
- Stop is always hit exactly and held for a full dwell.
- step = 0 with start != stop: holds start indefinitely until `abort`.
- Step sign opposite to the stop direction: the first step overshoots and stop is loaded.
- start == stop: a pass lasts exactly one dwell.
- `abort`, from any state: IDLE on the next edge. Has priority over a simultaneous `sample_clk_ce` and `cfg_valid`. `phase_increment` keeps its current value; no `sweep_done`.
- `cfg_valid` while busy is ignored (not latched).
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

## Timing
- Accept at edge t → ARM from t+1. Start is loaded at the first edge ≥ t+1 that has `sample_clk_ce` = 1. A `sample_clk_ce` in the acceptance cycle itself is not used.
- `phase_increment` is registered: a new value appears one cycle after the qualifying enable edge. The NCO first uses it on its next enable.
- Each value is held for exactly max(dwell,1) sample enables.
- `step_strobe` and `sweep_done` are single-cycle pulses, asserted in the cycle after the qualifying enable edge.
- `cfg_ready` rises the cycle after return to IDLE.

## Test plan
Tests use PHASE_WIDTH = 16, DWELL_WIDTH = 8 and `sample_clk_ce` every 4th cycle unless stated.
- TONE, start = 1000 → `phase_increment` = 1000 after the first enable following acceptance. One `step_strobe`, no `sweep_done`, `busy` drops in the same cycle as the update.
- ONESHOT, start = 100, stop = 130, step = 10, dwell = 2 → sequence 100, 110, 120, 130, each held 2 enables. `sweep_done` at the end; remains 130, then IDLE.
- ONESHOT, start = 100, stop = 125, step = 10, dwell = 1 → 100, 110, 120, 125 (clamped); `sweep_done` once.
- REPEAT, start = 50, stop = 20, step = −15, dwell = 1 → 50, 35, 20, 50, 35, … with `sweep_done` on each wrap. `abort` mid-pass → IDLE next cycle, value held.
- Boundaries:
  - `abort` + `cfg_valid` + `sample_clk_ce` in the same cycle in IDLE → config not accepted.
  - `cfg_valid` during DWELL → ignored.
  - dwell = 0 → behaves as 1.
  - `arst_n` low mid-sweep → `phase_increment` = 0, `cfg_ready` = 1 immediately.
- Signed range: start = 32700, stop = 32767, step = 50 → 32700, 32750, 32767. No wrap to negative.

Source files
------------

// File: rtl/nco_sweep_controller.sv
// Phase-increment sequencer for the NCO: single tone, one-shot sweep or repeating sweep,
// with every update aligned to the shared sample clock enable.
module nco_sweep_controller #(
    parameter int PHASE_WIDTH = 64,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          sample_clk_ce,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [1:0]                    cfg_mode,
    input  logic signed [PHASE_WIDTH-1:0] cfg_start_inc,
    input  logic signed [PHASE_WIDTH-1:0] cfg_stop_inc,
    input  logic signed [PHASE_WIDTH-1:0] cfg_step_inc,
    input  logic [DWELL_WIDTH-1:0]        cfg_dwell,
    input  logic                          abort,
    output logic signed [PHASE_WIDTH-1:0] phase_increment,
    output logic                          busy,
    output logic                          step_strobe,
    output logic                          sweep_done
);

    localparam logic [1:0] MODE_ONESHOT = 2'd1;
    localparam logic [1:0] MODE_REPEAT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_DWELL = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [1:0]                    r_mode;
    logic signed [PHASE_WIDTH-1:0] r_start;
    logic signed [PHASE_WIDTH-1:0] r_stop;
    logic signed [PHASE_WIDTH-1:0] r_step;
    logic [DWELL_WIDTH-1:0]        r_dwell;
    logic [DWELL_WIDTH-1:0]        r_dwell_cnt;
    logic signed [PHASE_WIDTH-1:0] r_phase;
    logic                          r_step_strobe;
    logic                          r_sweep_done;

    logic signed [PHASE_WIDTH-1:0] w_phase_nxt;
    logic [DWELL_WIDTH-1:0]        w_cnt_nxt;
    logic [DWELL_WIDTH-1:0]        w_reload;
    logic                          w_strobe_nxt;
    logic                          w_done_nxt;
    logic                          w_load_cfg;
    logic                          w_is_sweep;

    // Advance by one step in PHASE_WIDTH+1 bits so the sum cannot wrap; clamp to stop on overshoot.
    function automatic logic signed [PHASE_WIDTH-1:0] f_step_clamp(
        input logic signed [PHASE_WIDTH-1:0] cur,
        input logic signed [PHASE_WIDTH-1:0] step,
        input logic signed [PHASE_WIDTH-1:0] stop
    );
        logic signed [PHASE_WIDTH:0] nxt;
        logic signed [PHASE_WIDTH:0] stop_x;
        logic                        over;
        nxt    = $signed({cur[PHASE_WIDTH-1], cur}) + $signed({step[PHASE_WIDTH-1], step});
        stop_x = $signed({stop[PHASE_WIDTH-1], stop});
        over   = (!step[PHASE_WIDTH-1] && (step != '0) && (nxt > stop_x)) ||
                 (step[PHASE_WIDTH-1] && (nxt < stop_x));
        return over ? stop : nxt[PHASE_WIDTH-1:0];
    endfunction

    assign w_reload   = (r_dwell == '0) ? '0 : r_dwell - DWELL_WIDTH'(1);
    assign w_is_sweep = (r_mode == MODE_ONESHOT) || (r_mode == MODE_REPEAT);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state       <= S_IDLE;
            r_mode        <= '0;
            r_start       <= '0;
            r_stop        <= '0;
            r_step        <= '0;
            r_dwell       <= '0;
            r_dwell_cnt   <= '0;
            r_phase       <= '0;
            r_step_strobe <= 1'b0;
            r_sweep_done  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_dwell_cnt   <= w_cnt_nxt;
            r_phase       <= w_phase_nxt;
            r_step_strobe <= w_strobe_nxt;
            r_sweep_done  <= w_done_nxt;
            if (w_load_cfg) begin
                r_mode  <= cfg_mode;
                r_start <= cfg_start_inc;
                r_stop  <= cfg_stop_inc;
                r_step  <= cfg_step_inc;
                r_dwell <= cfg_dwell;
            end
        end
    end

    // Abort wins over both a pending enable and a new configuration.
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_cnt_nxt    = r_dwell_cnt;
        w_strobe_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_load_cfg   = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        w_load_cfg  = 1'b1;
                        w_state_nxt = S_ARM;
                    end
                end
                S_ARM: begin
                    if (sample_clk_ce) begin
                        w_phase_nxt  = r_start;
                        w_cnt_nxt    = w_reload;
                        w_strobe_nxt = 1'b1;
                        w_state_nxt  = w_is_sweep ? S_DWELL : S_IDLE;
                    end
                end
                S_DWELL: begin
                    if (sample_clk_ce) begin
                        if (r_dwell_cnt != '0) begin
                            w_cnt_nxt = r_dwell_cnt - DWELL_WIDTH'(1);
                        end else if (r_phase == r_stop) begin
                            w_done_nxt = 1'b1;
                            if (r_mode == MODE_REPEAT) begin
                                w_phase_nxt  = r_start;
                                w_cnt_nxt    = w_reload;
                                w_strobe_nxt = 1'b1;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end else begin
                            w_phase_nxt  = f_step_clamp(r_phase, r_step, r_stop);
                            w_cnt_nxt    = w_reload;
                            w_strobe_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign cfg_ready       = (r_state == S_IDLE) && !abort;
    assign busy            = (r_state != S_IDLE);
    assign phase_increment = r_phase;
    assign step_strobe     = r_step_strobe;
    assign sweep_done      = r_sweep_done;

endmodule

// File: tb/tb_nco_sweep_controller.sv
// Bench for nco_sweep_controller: directed plan table, hand-written corner sequences and
// randomized plans checked against an arithmetic model of the frequency plan.
module tb_nco_sweep_controller;

    localparam int PW = 16;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 arst_n;
    logic                 sample_clk_ce;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [1:0]           cfg_mode;
    logic signed [PW-1:0] cfg_start_inc;
    logic signed [PW-1:0] cfg_stop_inc;
    logic signed [PW-1:0] cfg_step_inc;
    logic [DW-1:0]        cfg_dwell;
    logic                 abort;
    logic signed [PW-1:0] phase_increment;
    logic                 busy;
    logic                 step_strobe;
    logic                 sweep_done;

    always #5 clk = ~clk;

    nco_sweep_controller #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .sample_clk_ce   (sample_clk_ce),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_mode        (cfg_mode),
        .cfg_start_inc   (cfg_start_inc),
        .cfg_stop_inc    (cfg_stop_inc),
        .cfg_step_inc    (cfg_step_inc),
        .cfg_dwell       (cfg_dwell),
        .abort           (abort),
        .phase_increment (phase_increment),
        .busy            (busy),
        .step_strobe     (step_strobe),
        .sweep_done      (sweep_done)
    );

    typedef struct {
        logic [1:0]     mode;
        int             start;
        int             stop;
        int             step;
        int             dwell;
        bit             poke;
        int             n;
        logic [3:0][15:0] ex;
    } vec_t;

    vec_t   vecs[$];
    int     checks = 0;
    int     errors = 0;
    int     ce_div = 0;
    bit     ce_rand = 1'b0;
    int     n_strobe;
    int     n_done;
    bit     loaded;
    bit     busy_at_load;
    longint got_q[$];
    int     exp_q[$];

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // One clock: observe the edge just taken, then drive the enable for the next edge and
    // record the increment the NCO will consume on that enable.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (step_strobe) begin
            if (!loaded) busy_at_load = busy;
            n_strobe++;
            loaded = 1'b1;
        end
        if (sweep_done) n_done++;
        ce_div = (ce_div + 1) % 4;
        sample_clk_ce = ce_rand ? ($urandom_range(0, 2) == 0) : (ce_div == 0);
        if (sample_clk_ce && busy && loaded) got_q.push_back(longint'(phase_increment));
    endtask

    // Frequency plan as a list of distinct values, one pass.
    task automatic model(input int start, input int stop, input int step);
        int v;
        int nxt;
        exp_q.delete();
        v = start;
        for (int k = 0; k < 1000; k++) begin
            exp_q.push_back(v);
            if (v == stop) break;
            nxt = v + step;
            if ((step > 0 && nxt > stop) || (step < 0 && nxt < stop)) nxt = stop;
            v = nxt;
        end
    endtask

    task automatic add_vec(input logic [1:0] mode, input int start, input int stop, input int step,
                           input int dwell, input bit poke, input int n,
                           input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.mode = mode; v.start = start; v.stop = stop; v.step = step; v.dwell = dwell;
        v.poke = poke; v.n = n;
        v.ex[0] = 16'(e0); v.ex[1] = 16'(e1); v.ex[2] = 16'(e2); v.ex[3] = 16'(e3);
        vecs.push_back(v);
    endtask

    task automatic start_plan(input string nm, input logic [1:0] mode, input int start,
                              input int stop, input int step, input int dwell);
        for (int w = 0; w < 50 && !cfg_ready; w++) cyc();
        chk({nm, " ready"}, cfg_ready, 1);
        got_q.delete();
        n_strobe = 0; n_done = 0; loaded = 1'b0; busy_at_load = 1'b0;
        cfg_mode = mode;
        cfg_start_inc = PW'(start);
        cfg_stop_inc = PW'(stop);
        cfg_step_inc = PW'(step);
        cfg_dwell = DW'(dwell);
        cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic run_plan(input string nm, input logic [1:0] mode, input int start,
                            input int stop, input int step, input int dwell, input bit poke);
        int  d;
        int  len;
        int  limit;
        int  poke_left;
        bit  fin;
        bit  sweep;
        longint held;
        d = (dwell == 0) ? 1 : dwell;
        len = exp_q.size();
        sweep = (mode == 2'd1) || (mode == 2'd2);
        limit = (mode == 2'd2) ? 2 * len * d + 1 : 1 << 20;
        poke_left = poke ? 3 : 0;
        start_plan(nm, mode, start, stop, step, dwell);
        fin = 1'b0;
        for (int c = 0; c < 20000 && !fin; c++) begin
            if (poke_left > 0 && loaded && busy) begin
                cfg_valid = 1'b1;
                cfg_mode = 2'd0;
                cfg_start_inc = PW'(start + 7);
                poke_left--;
            end else begin
                cfg_valid = 1'b0;
            end
            cyc();
            if ((loaded && !busy) || got_q.size() >= limit) fin = 1'b1;
        end
        cfg_valid = 1'b0;
        chk({nm, " completes"}, fin, 1);
        if (mode == 2'd2) begin
            held = longint'(phase_increment);
            abort = 1'b1;
            cyc();
            abort = 1'b0;
            chk({nm, " abort busy"}, busy, 0);
            chk({nm, " abort holds value"}, phase_increment, held);
        end else begin
            chk({nm, " final value"}, phase_increment, (mode == 2'd1) ? stop : start);
        end
        chk({nm, " busy at first load"}, busy_at_load, sweep);
        chk({nm, " enables seen"}, got_q.size(), (mode == 2'd2) ? limit : (sweep ? len * d : 0));
        for (int k = 0; k < got_q.size() && k < limit; k++)
            chk({nm, " value"}, got_q[k], exp_q[(k / d) % len]);
        chk({nm, " step_strobe count"}, n_strobe, (mode == 2'd2) ? 2 * len + 1 : (sweep ? len : 1));
        chk({nm, " sweep_done count"}, n_done, (mode == 2'd2) ? 2 : (sweep ? 1 : 0));
    endtask

    initial begin
        longint held;
        arst_n = 1'b0;
        sample_clk_ce = 1'b0; cfg_valid = 1'b0; cfg_mode = '0; abort = 1'b0;
        cfg_start_inc = '0; cfg_stop_inc = '0; cfg_step_inc = '0; cfg_dwell = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset phase_increment", phase_increment, 0);
        chk("reset cfg_ready", cfg_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset step_strobe", step_strobe, 0);
        chk("reset sweep_done", sweep_done, 0);
        @(negedge clk);
        arst_n = 1'b1;

        add_vec(2'd0, 1000, 0, 0, 1, 0, 1, 1000, 0, 0, 0);
        add_vec(2'd1, 100, 130, 10, 2, 1, 4, 100, 110, 120, 130);
        add_vec(2'd1, 100, 125, 10, 1, 0, 4, 100, 110, 120, 125);
        add_vec(2'd2, 50, 20, -15, 1, 0, 3, 50, 35, 20, 0);
        add_vec(2'd1, 32700, 32767, 50, 1, 0, 3, 32700, 32750, 32767, 0);
        add_vec(2'd1, 5, 8, 1, 0, 0, 4, 5, 6, 7, 8);
        add_vec(2'd1, 77, 77, 3, 3, 0, 1, 77, 0, 0, 0);
        add_vec(2'd1, 100, 130, -10, 1, 0, 2, 100, 130, 0, 0);
        add_vec(2'd3, -300, 40, 5, 2, 0, 1, -300, 0, 0, 0);
        add_vec(2'd2, -10, -10, 4, 2, 0, 1, -10, 0, 0, 0);
        foreach (vecs[i]) begin
            exp_q.delete();
            for (int k = 0; k < vecs[i].n; k++) exp_q.push_back(int'($signed(vecs[i].ex[k])));
            run_plan($sformatf("vec%0d", i), vecs[i].mode, vecs[i].start, vecs[i].stop,
                     vecs[i].step, vecs[i].dwell, vecs[i].poke);
        end

        // abort, cfg_valid and an enable together while idle: nothing is accepted
        cyc();
        held = longint'(phase_increment);
        n_strobe = 0;
        sample_clk_ce = 1'b1; abort = 1'b1; cfg_valid = 1'b1;
        cfg_mode = 2'd0; cfg_start_inc = 16'sd1234;
        #1;
        chk("cfg_ready low under abort", cfg_ready, 0);
        cyc();
        abort = 1'b0; cfg_valid = 1'b0;
        chk("abort+valid not accepted busy", busy, 0);
        repeat (10) cyc();
        chk("abort+valid no load", phase_increment, held);
        chk("abort+valid no strobe", n_strobe, 0);

        // zero step with start != stop holds start until aborted
        start_plan("zero step", 2'd1, 5, 9, 0, 1);
        repeat (40) cyc();
        chk("zero step still busy", busy, 1);
        chk("zero step enough enables", got_q.size() >= 8, 1);
        foreach (got_q[k]) chk("zero step value", got_q[k], 5);
        chk("zero step no sweep_done", n_done, 0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("zero step abort busy", busy, 0);
        chk("zero step abort no sweep_done", n_done, 0);

        // asynchronous reset in the middle of a sweep
        start_plan("mid reset", 2'd1, 0, 3000, 10, 1);
        repeat (30) cyc();
        chk("mid reset busy before", busy, 1);
        chk("mid reset value nonzero before", phase_increment != 0, 1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("mid reset phase_increment", phase_increment, 0);
        chk("mid reset cfg_ready", cfg_ready, 1);
        chk("mid reset busy", busy, 0);
        @(negedge clk);
        arst_n = 1'b1;

        for (int r = 0; r < 16; r++) begin
            logic [1:0] m;
            int st, sp, stp, dw;
            ce_rand = r[0];
            m   = 2'($urandom_range(0, 3));
            st  = int'($urandom_range(0, 400)) - 200;
            sp  = int'($urandom_range(0, 400)) - 200;
            stp = int'($urandom_range(5, 60));
            if ($urandom_range(0, 1) == 1) stp = -stp;
            dw  = int'($urandom_range(0, 3));
            model(st, sp, stp);
            run_plan($sformatf("rand%0d", r), m, st, sp, stp, dw, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
